// File: rtl/acp_wr_arbiter_if.sv
// Bundle of requester-side and ACP master-side write channel signals.
// The master modport is the arbiter's view (it masters the ACP port);
// the slave modport is the view of whatever sits around it.
interface acp_wr_arbiter_if #(
   parameter int NUM_REQ = 4
) ();
   logic [NUM_REQ-1:0]    req_awvalid;
   logic [NUM_REQ-1:0]    req_awready;
   logic [NUM_REQ*32-1:0] req_awaddr;
   logic [NUM_REQ*8-1:0]  req_awlen;
   logic [NUM_REQ*64-1:0] req_wdata;
   logic [NUM_REQ*8-1:0]  req_wstrb;
   logic [NUM_REQ-1:0]    req_wvalid;
   logic [NUM_REQ-1:0]    req_wready;
   logic [NUM_REQ-1:0]    req_bvalid;
   logic [1:0]            req_bresp;
   logic [NUM_REQ-1:0]    grant;

   logic [31:0] M_AXI_AWADDR;
   logic [7:0]  M_AXI_AWLEN;
   logic        M_AXI_AWVALID;
   logic        M_AXI_AWREADY;
   logic [2:0]  M_AXI_AWSIZE;
   logic [1:0]  M_AXI_AWBURST;
   logic [3:0]  M_AXI_AWCACHE;
   logic [4:0]  M_AXI_AWUSER;
   logic [2:0]  M_AXI_AWPROT;
   logic [63:0] M_AXI_WDATA;
   logic [7:0]  M_AXI_WSTRB;
   logic        M_AXI_WLAST;
   logic        M_AXI_WVALID;
   logic        M_AXI_WREADY;
   logic [1:0]  M_AXI_BRESP;
   logic        M_AXI_BVALID;
   logic        M_AXI_BREADY;

   modport master (
      input  req_awvalid, req_awaddr, req_awlen, req_wdata, req_wstrb, req_wvalid,
      output req_awready, req_wready, req_bvalid, req_bresp, grant,
      output M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWVALID, M_AXI_AWSIZE, M_AXI_AWBURST,
             M_AXI_AWCACHE, M_AXI_AWUSER, M_AXI_AWPROT,
             M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID, M_AXI_BREADY,
      input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID
   );

   modport slave (
      output req_awvalid, req_awaddr, req_awlen, req_wdata, req_wstrb, req_wvalid,
      input  req_awready, req_wready, req_bvalid, req_bresp, grant,
      input  M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWVALID, M_AXI_AWSIZE, M_AXI_AWBURST,
             M_AXI_AWCACHE, M_AXI_AWUSER, M_AXI_AWPROT,
             M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID, M_AXI_BREADY,
      output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID
   );
endinterface

// File: rtl/acp_wr_arbiter.sv
// Round-robin arbiter sharing the single ACP AXI write path among NUM_REQ
// requesters. One burst is outstanding at a time; the grant is held until
// that burst's write response returns.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no owner; pick next requester round-robin from rr pointer
// ADDR  | AWVALID driven from latched address/len until AWREADY
// DATA  | W channel muxed from owner; beat counter generates WLAST
// RESP  | BREADY high; route the single B response back to the owner
module acp_wr_arbiter #(
   parameter int         NUM_REQ   = 4,
   parameter logic [3:0] AWCACHE_V = 4'hF,
   parameter logic [4:0] AWUSER_V  = 5'h01
) (
   input logic clk,
   input logic rst,
   acp_wr_arbiter_if.master bus
);
   localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

   state_t             state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [IDXW-1:0]    gidx_q, gidx_d;
   logic [IDXW-1:0]    rr_q, rr_d;
   logic [31:0]        addr_q, addr_d;
   logic [7:0]         awlen_q, awlen_d;
   logic [7:0]         wlen_q, wlen_d;
   logic [7:0]         beat_q, beat_d;

   logic               pick_found;
   logic [IDXW-1:0]    pick_idx;

   // Fixed ACP sideband: 8-byte beats, INCR, coherent write-back allocate.
   assign bus.M_AXI_AWSIZE  = 3'b011;
   assign bus.M_AXI_AWBURST = 2'b01;
   assign bus.M_AXI_AWCACHE = AWCACHE_V;
   assign bus.M_AXI_AWUSER  = AWUSER_V;
   assign bus.M_AXI_AWPROT  = 3'b000;
   assign bus.M_AXI_AWADDR  = addr_q;
   assign bus.M_AXI_AWLEN   = awlen_q;
   assign bus.grant         = grant_q;

   // Round-robin pick: first requesting index at or after rr pointer, wrapping.
   always_comb begin
      int idx;
      idx        = 0;
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(rr_q) + k) % NUM_REQ;
         if (!pick_found && bus.req_awvalid[idx]) begin
            pick_found = 1'b1;
            pick_idx   = IDXW'(idx);
         end
      end
   end

   // Next-state logic and channel muxing; every output defaults to idle values.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      gidx_d  = gidx_q;
      rr_d    = rr_q;
      addr_d  = addr_q;
      awlen_d = awlen_q;
      wlen_d  = wlen_q;
      beat_d  = beat_q;

      bus.M_AXI_AWVALID = 1'b0;
      bus.M_AXI_WVALID  = 1'b0;
      bus.M_AXI_WDATA   = '0;
      bus.M_AXI_WSTRB   = '0;
      bus.M_AXI_WLAST   = 1'b0;
      bus.M_AXI_BREADY  = 1'b0;
      bus.req_awready   = '0;
      bus.req_wready    = '0;
      bus.req_bvalid    = '0;
      bus.req_bresp     = '0;

      case (state_q)
         IDLE: begin
            if (pick_found) begin
               grant_d           = '0;
               grant_d[pick_idx] = 1'b1;
               gidx_d            = pick_idx;
               addr_d            = bus.req_awaddr[32*pick_idx +: 32];
               awlen_d           = bus.req_awlen[8*pick_idx +: 8];
               state_d           = ADDR;
            end
         end
         ADDR: begin
            bus.M_AXI_AWVALID = 1'b1;
            bus.req_awready   = grant_q & {NUM_REQ{bus.M_AXI_AWREADY}};
            if (bus.M_AXI_AWREADY) begin
               wlen_d  = awlen_q;
               beat_d  = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            bus.M_AXI_WVALID = bus.req_wvalid[gidx_q];
            bus.M_AXI_WDATA  = bus.req_wdata[64*gidx_q +: 64];
            bus.M_AXI_WSTRB  = bus.req_wstrb[8*gidx_q +: 8];
            bus.M_AXI_WLAST  = (beat_q == wlen_q);
            bus.req_wready   = grant_q & {NUM_REQ{bus.M_AXI_WREADY}};
            if (bus.M_AXI_WVALID && bus.M_AXI_WREADY) begin
               beat_d = beat_q + 8'd1;
               if (beat_q == wlen_q) begin
                  state_d = RESP;
               end
            end
         end
         RESP: begin
            bus.M_AXI_BREADY = 1'b1;
            if (bus.M_AXI_BVALID) begin
               bus.req_bvalid = grant_q;
               bus.req_bresp  = bus.M_AXI_BRESP;
               rr_d           = (int'(gidx_q) == NUM_REQ - 1) ? '0 : gidx_q + 1'b1;
               grant_d        = '0;
               state_d        = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         gidx_q  <= '0;
         rr_q    <= '0;
         addr_q  <= '0;
         awlen_q <= '0;
         wlen_q  <= '0;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         gidx_q  <= gidx_d;
         rr_q    <= rr_d;
         addr_q  <= addr_d;
         awlen_q <= awlen_d;
         wlen_q  <= wlen_d;
         beat_q  <= beat_d;
      end
   end
endmodule

// File: tb/tb_acp_wr_arbiter.sv
// Directed bench for acp_wr_arbiter: single burst, round-robin order,
// address stall, gapped data, error response and reset mid-burst.
module tb_acp_wr_arbiter;
   localparam int N = 4;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   int   hs;
   logic [3:0] exp_g;

   always #5 clk = ~clk;

   acp_wr_arbiter_if #(.NUM_REQ(N)) bus ();

   acp_wr_arbiter #(.NUM_REQ(N), .AWCACHE_V(4'hF), .AWUSER_V(5'h01)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic check_quiet(input string tag);
      chk({tag, "_grant"},   bus.grant, 0);
      chk({tag, "_awvalid"}, bus.M_AXI_AWVALID, 0);
      chk({tag, "_wvalid"},  bus.M_AXI_WVALID, 0);
      chk({tag, "_wlast"},   bus.M_AXI_WLAST, 0);
      chk({tag, "_bready"},  bus.M_AXI_BREADY, 0);
      chk({tag, "_awaddr"},  bus.M_AXI_AWADDR, 0);
      chk({tag, "_awlen"},   bus.M_AXI_AWLEN, 0);
      chk({tag, "_wdata"},   bus.M_AXI_WDATA, 0);
      chk({tag, "_wstrb"},   bus.M_AXI_WSTRB, 0);
      chk({tag, "_req_awready"}, bus.req_awready, 0);
      chk({tag, "_req_wready"},  bus.req_wready, 0);
      chk({tag, "_req_bvalid"},  bus.req_bvalid, 0);
      chk({tag, "_req_bresp"},   bus.req_bresp, 0);
   endtask

   initial begin
      rst = 1'b1;
      bus.req_awvalid   = '0;
      bus.req_awaddr    = '0;
      bus.req_awlen     = '0;
      bus.req_wdata     = '0;
      bus.req_wstrb     = '0;
      bus.req_wvalid    = '0;
      bus.M_AXI_AWREADY = 1'b0;
      bus.M_AXI_WREADY  = 1'b0;
      bus.M_AXI_BRESP   = 2'b00;
      bus.M_AXI_BVALID  = 1'b0;

      // Reset state and fixed sideband
      tick();
      tick();
      settle();
      check_quiet("reset");
      chk("awsize",  bus.M_AXI_AWSIZE, 3'b011);
      chk("awburst", bus.M_AXI_AWBURST, 2'b01);
      chk("awcache", bus.M_AXI_AWCACHE, 4'hF);
      chk("awuser",  bus.M_AXI_AWUSER, 5'h01);
      chk("awprot",  bus.M_AXI_AWPROT, 3'b000);
      rst = 1'b0;

      for (int i = 0; i < N; i++) begin
         bus.req_awaddr[32*i +: 32] = 32'h1000_0000 + 32'(i) * 32'h100;
         bus.req_wdata[64*i +: 64]  = 64'hD0 + 64'(i);
         bus.req_wstrb[8*i +: 8]    = 8'hF0 | 8'(i);
      end

      // T1: req0 len=3, ready tied high
      bus.M_AXI_AWREADY = 1'b1;
      bus.M_AXI_WREADY  = 1'b1;
      bus.req_awlen[7:0] = 8'd3;
      bus.req_wstrb[7:0] = 8'hFF;
      bus.req_wvalid  = 4'b0001;
      bus.req_wdata[63:0] = 64'hA0;
      bus.req_awvalid = 4'b0001;
      tick();
      settle();
      chk("t1_awvalid", bus.M_AXI_AWVALID, 1);
      chk("t1_grant",   bus.grant, 4'b0001);
      chk("t1_awaddr",  bus.M_AXI_AWADDR, 32'h1000_0000);
      chk("t1_awlen",   bus.M_AXI_AWLEN, 8'd3);
      chk("t1_req_awready", bus.req_awready, 4'b0001);
      bus.req_awvalid = 4'b0000;
      for (int b = 0; b < 4; b++) begin
         tick();
         bus.req_wdata[63:0] = 64'hA0 + 64'(b);
         settle();
         chk("t1_wvalid", bus.M_AXI_WVALID, 1);
         chk("t1_wlast",  bus.M_AXI_WLAST, (b == 3));
         chk("t1_wdata",  bus.M_AXI_WDATA, 64'hA0 + 64'(b));
         chk("t1_wstrb",  bus.M_AXI_WSTRB, 8'hFF);
         chk("t1_req_wready", bus.req_wready, 4'b0001);
      end
      tick();
      settle();
      chk("t1_bready", bus.M_AXI_BREADY, 1);
      chk("t1_bvalid_early", bus.req_bvalid, 0);
      bus.M_AXI_BVALID = 1'b1;
      bus.M_AXI_BRESP  = 2'b00;
      settle();
      chk("t1_req_bvalid", bus.req_bvalid, 4'b0001);
      chk("t1_req_bresp",  bus.req_bresp, 2'b00);
      tick();
      bus.M_AXI_BVALID = 1'b0;
      settle();
      chk("t1_bvalid_pulse", bus.req_bvalid, 0);
      chk("t1_grant_idle",   bus.grant, 0);
      chk("t1_bready_idle",  bus.M_AXI_BREADY, 0);

      // T2: all requesting len=0, round-robin from pointer 0
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.req_awlen   = '0;
      bus.req_wvalid  = 4'b1111;
      bus.req_wdata[63:0] = 64'hD0;
      bus.req_awvalid = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         exp_g = 4'b0001 << (n % 4);
         tick();
         settle();
         chk("t2_grant",  bus.grant, exp_g);
         chk("t2_awaddr", bus.M_AXI_AWADDR, 32'h1000_0000 + 32'(n % 4) * 32'h100);
         tick();
         settle();
         chk("t2_wlast",  bus.M_AXI_WLAST, 1);
         chk("t2_wdata",  bus.M_AXI_WDATA, 64'hD0 + 64'(n % 4));
         chk("t2_req_wready", bus.req_wready, exp_g);
         tick();
         bus.M_AXI_BVALID = 1'b1;
         settle();
         chk("t2_req_bvalid", bus.req_bvalid, exp_g);
         tick();
         bus.M_AXI_BVALID = 1'b0;
         settle();
         chk("t2_grant_idle", bus.grant, 0);
      end
      bus.req_awvalid = 4'b0000;

      // T3: req1 len=2 with AWREADY held low 5 cycles (pointer now 1)
      bus.req_awaddr[63:32] = 32'h2000_0040;
      bus.req_awlen[15:8]   = 8'd2;
      bus.M_AXI_AWREADY = 1'b0;
      bus.req_awvalid = 4'b0010;
      tick();
      bus.req_awvalid = 4'b0000;
      settle();
      for (int c = 0; c < 5; c++) begin
         if (c > 0) begin
            tick();
            settle();
         end
         chk("t3_awvalid", bus.M_AXI_AWVALID, 1);
         chk("t3_awaddr",  bus.M_AXI_AWADDR, 32'h2000_0040);
         chk("t3_awlen",   bus.M_AXI_AWLEN, 8'd2);
         chk("t3_req_awready_low", bus.req_awready, 0);
      end
      bus.M_AXI_AWREADY = 1'b1;
      settle();
      chk("t3_req_awready", bus.req_awready, 4'b0010);
      tick();
      settle();
      chk("t3_req_awready_after", bus.req_awready, 0);
      for (int b = 0; b < 3; b++) begin
         if (b > 0) begin
            tick();
            settle();
         end
         chk("t3_wlast", bus.M_AXI_WLAST, (b == 2));
         chk("t3_req_wready", bus.req_wready, 4'b0010);
      end
      tick();
      bus.M_AXI_BVALID = 1'b1;
      settle();
      chk("t3_req_bvalid", bus.req_bvalid, 4'b0010);
      tick();
      bus.M_AXI_BVALID = 1'b0;

      // T4: req2 len=7, WREADY alternating and requester gaps (pointer now 2)
      bus.req_awaddr[95:64] = 32'h3000_0000;
      bus.req_awlen[23:16]  = 8'd7;
      bus.req_wdata[191:128] = 64'hC2;
      bus.req_awvalid = 4'b0100;
      tick();
      settle();
      chk("t4_grant", bus.grant, 4'b0100);
      chk("t4_req_awready", bus.req_awready, 4'b0100);
      bus.req_awvalid = 4'b0000;
      tick();
      hs = 0;
      for (int cyc = 0; cyc < 40 && hs < 8; cyc++) begin
         bus.M_AXI_WREADY = ((cyc % 2) == 0);
         bus.req_wvalid   = 4'b1011 | (((cyc % 3) != 2) ? 4'b0100 : 4'b0000);
         settle();
         chk("t4_wready_others", bus.req_wready & 4'b1011, 0);
         if (bus.M_AXI_WVALID && bus.M_AXI_WREADY) begin
            chk("t4_wlast", bus.M_AXI_WLAST, (hs == 7));
            chk("t4_wdata", bus.M_AXI_WDATA, 64'hC2);
            hs++;
         end
         tick();
      end
      chk("t4_handshakes", hs, 8);
      chk("t4_bready", bus.M_AXI_BREADY, 1);
      chk("t4_wvalid_resp", bus.M_AXI_WVALID, 0);

      // T5: SLVERR response routed to req2; pointer advances to 3
      bus.M_AXI_BVALID = 1'b1;
      bus.M_AXI_BRESP  = 2'b10;
      settle();
      chk("t5_req_bvalid", bus.req_bvalid, 4'b0100);
      chk("t5_req_bresp",  bus.req_bresp, 2'b10);
      tick();
      bus.M_AXI_BVALID = 1'b0;
      bus.M_AXI_BRESP  = 2'b00;
      bus.M_AXI_WREADY = 1'b1;
      bus.req_wvalid   = 4'b1111;
      bus.req_awlen    = '0;
      bus.req_awvalid  = 4'b1001;
      tick();
      settle();
      chk("t5_rr_grant", bus.grant, 4'b1000);
      bus.req_awvalid = 4'b0000;
      tick();
      settle();
      chk("t5_wlast", bus.M_AXI_WLAST, 1);
      tick();
      bus.M_AXI_BVALID = 1'b1;
      settle();
      chk("t5_req_bvalid3", bus.req_bvalid, 4'b1000);
      tick();
      bus.M_AXI_BVALID = 1'b0;

      // T6: reset during the third beat of a len=7 burst (pointer now 0)
      bus.req_awlen[15:8] = 8'd7;
      bus.req_awvalid = 4'b0010;
      tick();
      bus.req_awvalid = 4'b0000;
      settle();
      chk("t6_grant", bus.grant, 4'b0010);
      tick();
      tick();
      tick();
      settle();
      chk("t6_wvalid_mid", bus.M_AXI_WVALID, 1);
      chk("t6_wlast_mid",  bus.M_AXI_WLAST, 0);
      rst = 1'b1;
      tick();
      settle();
      check_quiet("t6_rst");
      rst = 1'b0;
      bus.req_awvalid = 4'b1000;
      tick();
      settle();
      chk("t6_grant3",   bus.grant, 4'b1000);
      chk("t6_awvalid3", bus.M_AXI_AWVALID, 1);
      chk("t6_awaddr3",  bus.M_AXI_AWADDR, 32'h1000_0300);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
